// File: rtl/camera_pattern_source.sv
// camera_pattern_source: transmit end of the camera pixel interface.
// Emits ramp, checker, solid or LFSR frames as a byte-serial stream.
module camera_pattern_source #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 48,
   parameter int BPP    = 3,
   parameter int HBLANK = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pause,
   input  logic [1:0] pattern_sel,
   input  logic [7:0] solid_value,
   output logic       data_valid,
   output logic [7:0] camera_data,
   output logic       line_end,
   output logic       frame_done,
   output logic       busy
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int CW = (BPP > 1) ? $clog2(BPP) : 1;
   localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

   localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);
   localparam logic [CW-1:0] CMAX = CW'(BPP - 1);
   localparam logic [BW-1:0] BMAX = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, DONE} state_t;

   state_t        state_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [CW-1:0] ch_q;
   logic [BW-1:0] blank_q;
   logic [7:0]    lfsr_q;
   logic          en_q;
   logic [1:0]    sel_q;
   logic [7:0]    solid_q;
   logic          valid_q;
   logic [7:0]    data_q;
   logic          le_q;
   logic          fd_q;
   logic          busy_q;

   logic          start_d;
   logic          emit_d;
   logic [1:0]    sel_d;
   logic [7:0]    solid_d;
   logic [7:0]    lfsr_cur;
   logic [7:0]    lfsr_d;
   logic [7:0]    byte_d;

   // On the start edge the frame settings come straight from the inputs.
   always_comb begin
      start_d  = (state_q == IDLE) && enable && !en_q;
      emit_d   = !pause && enable && (start_d || state_q == ACTIVE);
      sel_d    = start_d ? pattern_sel : sel_q;
      solid_d  = start_d ? solid_value : solid_q;
      lfsr_cur = start_d ? 8'hA5 : lfsr_q;
      lfsr_d   = {lfsr_cur[6:0],
                  lfsr_cur[7] ^ lfsr_cur[5] ^ lfsr_cur[4] ^ lfsr_cur[3]};
      byte_d   = 8'h00;
      unique case (sel_d)
         2'd0: byte_d = 8'(x_q) + 8'(y_q) + 8'({ch_q, 6'b0});
         2'd1: byte_d = (((32'(x_q) ^ 32'(y_q)) & 32'd8) != 0) ? 8'hFF : 8'h00;
         2'd2: byte_d = solid_d;
         default: byte_d = lfsr_cur;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         ch_q    <= '0;
         blank_q <= '0;
         lfsr_q  <= 8'hA5;
         en_q    <= 1'b0;
         sel_q   <= '0;
         solid_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         le_q    <= 1'b0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         en_q    <= enable;
         valid_q <= 1'b0;
         le_q    <= 1'b0;
         fd_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_d) begin
                  state_q <= ACTIVE;
                  busy_q  <= 1'b1;
                  sel_q   <= pattern_sel;
                  solid_q <= solid_value;
                  lfsr_q  <= 8'hA5;
               end
            end
            ACTIVE, BLANK: begin
               if (!enable) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  x_q     <= '0;
                  y_q     <= '0;
                  ch_q    <= '0;
                  blank_q <= '0;
               end else if (state_q == BLANK && !pause) begin
                  if (blank_q == BMAX) begin
                     blank_q <= '0;
                     state_q <= ACTIVE;
                  end else begin
                     blank_q <= blank_q + BW'(1);
                  end
               end
            end
            default: begin
               fd_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
         // Byte emission advances ch, then x, then y; overrides state.
         if (emit_d) begin
            valid_q <= 1'b1;
            data_q  <= byte_d;
            lfsr_q  <= lfsr_d;
            if (ch_q != CMAX) begin
               ch_q <= ch_q + CW'(1);
            end else begin
               ch_q <= '0;
               if (x_q != XMAX) begin
                  x_q <= x_q + XW'(1);
               end else begin
                  x_q  <= '0;
                  le_q <= 1'b1;
                  if (y_q == YMAX) begin
                     y_q     <= '0;
                     state_q <= DONE;
                  end else begin
                     y_q     <= y_q + YW'(1);
                     state_q <= (HBLANK > 0) ? BLANK : ACTIVE;
                  end
               end
            end
         end
      end
   end

   assign data_valid  = valid_q;
   assign camera_data = data_q;
   assign line_end    = le_q;
   assign frame_done  = fd_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_camera_pattern_source.sv
// tb_camera_pattern_source: directed bench for the pattern source.
// Instance a: 4x2, 3 bytes/pixel, 2 blank cycles; instance b: 16x9 mono.
module tb_camera_pattern_source;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_a;
   logic       en_b;
   logic       pause;
   logic [1:0] sel;
   logic [7:0] solid;
   logic       va, lea, fda, ba;
   logic [7:0] da;
   logic       vb, leb, fdb, bb;
   logic [7:0] db;

   int tests = 0;
   int fails = 0;
   int fdc;
   int lec;
   int nv;
   logic [7:0] got[$];

   logic [7:0] exp_a [24] = '{
      8'h00, 8'h40, 8'h80, 8'h01, 8'h41, 8'h81,
      8'h02, 8'h42, 8'h82, 8'h03, 8'h43, 8'h83,
      8'h01, 8'h41, 8'h81, 8'h02, 8'h42, 8'h82,
      8'h03, 8'h43, 8'h83, 8'h04, 8'h44, 8'h84};

   always #5 clk = ~clk;

   camera_pattern_source #(
      .IMG_W(4), .IMG_H(2), .BPP(3), .HBLANK(2)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a), .pause(pause),
      .pattern_sel(sel), .solid_value(solid),
      .data_valid(va), .camera_data(da), .line_end(lea),
      .frame_done(fda), .busy(ba)
   );

   camera_pattern_source #(
      .IMG_W(16), .IMG_H(9), .BPP(1), .HBLANK(0)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b), .pause(pause),
      .pattern_sel(sel), .solid_value(solid),
      .data_valid(vb), .camera_data(db), .line_end(leb),
      .frame_done(fdb), .busy(bb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one frame on instance a (b=0) or b (b=1), pausing cycles plo..phi.
   task automatic run_frame(input bit b, input int plo, input int phi,
                            input logic [7:0] hold);
      got.delete();
      fdc = -1;
      lec = 0;
      if (b) en_b = 1'b1;
      else   en_a = 1'b1;
      for (int n = 1; n <= 400 && fdc < 0; n++) begin
         pause = (n >= plo && n <= phi);
         tick();
         if (n >= plo && n <= phi) begin
            chk("pause_valid", b ? vb : va, 0);
            chk("pause_hold", b ? db : da, hold);
         end
         if (b ? vb : va) got.push_back(b ? db : da);
         if (b ? leb : lea) lec++;
         if (b ? fdb : fda) fdc = n;
      end
      pause = 1'b0;
      chk("frame_timeout", fdc > 0, 1);
      en_a = 1'b0;
      en_b = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      en_a  = 1'b0;
      en_b  = 1'b0;
      pause = 1'b0;
      sel   = 2'd0;
      solid = 8'h00;
      tick();
      tick();
      chk("reset_a", {va, da, lea, fda, ba}, 0);
      chk("reset_b", {vb, db, leb, fdb, bb}, 0);
      rst_n = 1'b1;
      tick();

      // Ramp frame, checked cycle by cycle
      nv   = 0;
      en_a = 1'b1;
      for (int n = 1; n <= 27; n++) begin
         tick();
         chk($sformatf("ramp_valid_T%0d", n), va,
             (n <= 12) || (n >= 15 && n <= 26));
         if (n <= 12) chk($sformatf("ramp_data_T%0d", n), da, exp_a[n-1]);
         if (n >= 15 && n <= 26)
            chk($sformatf("ramp_data_T%0d", n), da, exp_a[n-3]);
         chk($sformatf("ramp_le_T%0d", n), lea, n == 12 || n == 26);
         chk($sformatf("ramp_fd_T%0d", n), fda, n == 27);
         chk($sformatf("ramp_busy_T%0d", n), ba, n <= 26);
         if (va) nv++;
      end
      chk("ramp_count", nv, 24);
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("no_restart", {va, fda, ba}, 0);
      end
      en_a = 1'b0;
      tick();

      // Pause for three edges mid-row
      sel = 2'd0;
      run_frame(1'b0, 4, 6, 8'h80);
      chk("pause_fd_cycle", fdc, 30);
      chk("pause_len", got.size(), 24);
      chk("pause_le_cnt", lec, 2);
      for (int i = 0; i < 24; i++)
         chk($sformatf("pause_seq%0d", i), got[i], exp_a[i]);

      // LFSR frames reseed at each start
      sel = 2'd3;
      run_frame(1'b0, 0, -1, 8'h00);
      chk("lfsr_len", got.size(), 24);
      chk("lfsr_b0", got[0], 8'hA5);
      chk("lfsr_b1", got[1], 8'h4A);
      chk("lfsr_b2", got[2], 8'h95);
      chk("lfsr_b3", got[3], 8'h2A);
      run_frame(1'b0, 0, -1, 8'h00);
      chk("lfsr2_b0", got[0], 8'hA5);
      chk("lfsr2_b1", got[1], 8'h4A);

      // Solid value and pattern latched at start, then early abort
      sel   = 2'd2;
      solid = 8'h5A;
      en_a  = 1'b1;
      tick();
      chk("solid_b0", da, 8'h5A);
      solid = 8'h33;
      sel   = 2'd0;
      tick();
      chk("solid_latched", da, 8'h5A);
      en_a = 1'b0;
      tick();
      chk("solid_abort", {va, ba}, 0);
      tick();

      // Abort after five bytes, then a clean full frame
      sel  = 2'd0;
      en_a = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         tick();
         chk($sformatf("abort_pre%0d", n), da, exp_a[n-1]);
      end
      en_a = 1'b0;
      tick();
      chk("abort_valid", va, 0);
      chk("abort_busy", ba, 0);
      nv = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (fda || va) nv++;
      end
      chk("abort_quiet", nv, 0);
      run_frame(1'b0, 0, -1, 8'h00);
      chk("post_abort_fd", fdc, 27);
      chk("post_abort_len", got.size(), 24);
      for (int i = 0; i < 24; i++)
         chk($sformatf("post_abort_seq%0d", i), got[i], exp_a[i]);

      // Reset in the middle of a frame
      en_a = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      chk("pre_reset_busy", ba, 1);
      rst_n = 1'b0;
      tick();
      chk("midreset_out", {va, da, lea, fda, ba}, 0);
      rst_n = 1'b1;
      en_a  = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("post_reset_idle", {va, ba}, 0);
      end
      en_a = 1'b1;
      tick();
      chk("post_reset_start", {va, da, ba}, {1'b1, 8'h00, 1'b1});
      en_a = 1'b0;
      tick();
      tick();

      // Checker on the 16x9 mono instance, no horizontal blank
      sel = 2'd1;
      run_frame(1'b1, 0, -1, 8'h00);
      chk("chk_len", got.size(), 144);
      chk("chk_fd", fdc, 145);
      chk("chk_le_cnt", lec, 9);
      chk("chk_r0x0", got[0], 8'h00);
      chk("chk_r0x7", got[7], 8'h00);
      chk("chk_r0x8", got[8], 8'hFF);
      chk("chk_r0x15", got[15], 8'hFF);
      chk("chk_r1x0", got[16], 8'h00);
      chk("chk_r8x0", got[128], 8'hFF);
      chk("chk_r8x7", got[135], 8'hFF);
      chk("chk_r8x8", got[136], 8'h00);
      chk("chk_r8x15", got[143], 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
